// File: rtl/conv2d_stream_engine.sv
// Streaming valid-mode KxK 2-D convolution: K-row circular line buffer,
// one-product-per-cycle MAC and optional ReLU on each result.
module conv2d_stream_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    localparam int KA_W  = (K > 1) ? $clog2(K*K) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     kw_en,
    input  logic [KA_W-1:0]          kw_addr,
    input  logic signed [DATA_W-1:0] kw_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int OW  = IMG_W - K + 1;
    localparam int OH  = IMG_H - K + 1;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int HW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int RW  = (K > 1) ? $clog2(K) : 1;
    localparam int RW1 = RW + 1;
    localparam int NW  = $clog2(K*IMG_W + 1);

    typedef enum logic [2:0] {IDLE, FILL, MAC, EMIT, DONE} state_t;
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] kern [K*K];
    logic signed [DATA_W-1:0] lbuf [K][IMG_W];
    logic [CW-1:0]            wcol, ocol, rd_col;
    logic [RW-1:0]            wr_row, rd_row, kr, kc;
    logic [RW:0]              row_sum;
    logic [KA_W-1:0]          kidx;
    logic [HW-1:0]            orow;
    logic [NW-1:0]            need;
    logic                     relu, mac_last, ocol_end, orow_end;
    logic signed [ACC_W-1:0]  acc, acc_nxt, res, prod_x;

    assign mac_last = (kr == RW'(K-1)) && (kc == RW'(K-1));
    assign ocol_end = (ocol == CW'(OW-1));
    assign orow_end = (orow == HW'(OH-1));

    // wr_row always points at the oldest buffered row, so window row kr
    // lives kr rows after it in the circular buffer.
    assign row_sum = {1'b0, wr_row} + {1'b0, kr};
    assign rd_row  = (row_sum >= RW1'(K)) ? RW'(row_sum - RW1'(K)) : RW'(row_sum);
    assign rd_col  = ocol + CW'(kc);
    assign kidx    = KA_W'(int'(kr) * K + int'(kc));
    assign prod_x  = ACC_W'(kern[kidx]) * ACC_W'(lbuf[rd_row][rd_col]);
    assign acc_nxt = acc + prod_x;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && need == NW'(1)) state_nxt = MAC;
            end
            MAC: if (mac_last) state_nxt = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = !ocol_end ? MAC : (!orow_end ? FILL : DONE);
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_last = out_valid && ocol_end && orow_end;
    assign out_data = res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < K*K; i++) kern[i] <= '0;
            wcol   <= '0;
            wr_row <= '0;
            ocol   <= '0;
            orow   <= '0;
            kr     <= '0;
            kc     <= '0;
            need   <= '0;
            relu   <= 1'b0;
            acc    <= '0;
            res    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (kw_en && int'(kw_addr) < K*K) kern[kw_addr] <= kw_data;
                    if (start) begin
                        relu   <= relu_en;
                        wcol   <= '0;
                        wr_row <= '0;
                        ocol   <= '0;
                        orow   <= '0;
                        need   <= NW'(K*IMG_W);
                    end
                end
                FILL: if (in_valid) begin
                    wcol <= (wcol == CW'(IMG_W-1)) ? '0 : wcol + CW'(1);
                    if (wcol == CW'(IMG_W-1))
                        wr_row <= (wr_row == RW'(K-1)) ? '0 : wr_row + RW'(1);
                    need <= need - NW'(1);
                    acc  <= '0;
                    kr   <= '0;
                    kc   <= '0;
                end
                MAC: begin
                    acc <= acc_nxt;
                    kc  <= (kc == RW'(K-1)) ? '0 : kc + RW'(1);
                    if (kc == RW'(K-1)) kr <= (kr == RW'(K-1)) ? '0 : kr + RW'(1);
                    if (mac_last) res <= (relu && acc_nxt < 0) ? '0 : acc_nxt;
                end
                EMIT: if (out_ready) begin
                    acc <= '0;
                    kr  <= '0;
                    kc  <= '0;
                    if (!ocol_end) begin
                        ocol <= ocol + CW'(1);
                    end else if (!orow_end) begin
                        orow <= orow + HW'(1);
                        ocol <= '0;
                        need <= NW'(IMG_W);
                    end
                end
                default: ;
            endcase
        end
    end

    // The buffer needs no reset: every row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (state == FILL && in_valid) lbuf[wr_row][wcol] <= in_data;
    end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine: a plain-arithmetic convolution
// model fills the expected queue, a monitor pops it on every output handshake.
module tb_conv2d_stream_engine;
    localparam int DATA_W = 16, ACC_W = 32, IMG_W = 8, IMG_H = 8, K = 3;
    localparam int OW = IMG_W - K + 1, OH = IMG_H - K + 1, NPIX = IMG_W * IMG_H;
    localparam int KA_W = $clog2(K*K);
    localparam int BUDGET = 6000;

    logic clk = 0, rst = 0, start = 0, relu_en = 0, kw_en = 0;
    logic in_valid = 0, out_ready = 0;
    logic [KA_W-1:0] kw_addr = '0;
    logic signed [DATA_W-1:0] kw_data = '0, in_data = '0;
    logic in_ready, out_valid, out_last, busy, done;
    logic signed [ACC_W-1:0] out_data;

    conv2d_stream_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IMG_W(IMG_W),
                           .IMG_H(IMG_H), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .kw_en(kw_en), .kw_addr(kw_addr), .kw_data(kw_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int img [IMG_H][IMG_W];
    int ker [K*K];
    bit relu_m, abort;
    logic signed [ACC_W-1:0] exp_d[$];
    bit exp_l[$];
    int n_cmp = 0, n_bad = 0, n_out = 0, done_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, required completion", name);
    endtask

    // Reference: direct valid-mode convolution, wrapped to ACC_W bits.
    function automatic void push_expected();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                longint s = 0;
                logic signed [ACC_W-1:0] v;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s += longint'(ker[i*K+j]) * longint'(img[r+i][c+j]);
                v = ACC_W'(s);
                if (relu_m && v < 0) v = '0;
                exp_d.push_back(v);
                exp_l.push_back(r == OH-1 && c == OW-1);
            end
    endfunction

    logic signed [ACC_W-1:0] held_d;
    bit held_v = 0, held_r = 0, held_l = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && held_v && !held_r) begin
            check("stall_hold_data", out_data, held_d);
            check("stall_hold_last", out_last, held_l);
        end
        if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                fail("unexpected_output");
            end else begin
                logic signed [ACC_W-1:0] ed;
                bit el;
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                check("out_data", out_data, ed);
                check("out_last", out_last, el);
            end
            n_out++;
        end
        held_v = out_valid;
        held_r = out_ready;
        held_d = out_data;
        held_l = out_last;
    end

    task automatic load_kernel();
        for (int i = 0; i < K*K; i++) begin
            @(negedge clk);
            kw_en = 1; kw_addr = KA_W'(i); kw_data = DATA_W'(ker[i]);
        end
        @(negedge clk);
        kw_en = 0;
    endtask

    task automatic feed(input int vmode);
        int idx = 0, cyc = 0;
        bit hs;
        while (idx < NPIX && cyc < BUDGET && !abort) begin
            case (vmode)
                0: in_valid = 1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = DATA_W'(img[idx / IMG_W][idx % IMG_W]);
            hs = in_valid && in_ready;
            @(negedge clk);
            if (hs) idx++;
            cyc++;
        end
        in_valid = 0;
        if (idx < NPIX && !abort) fail("feed_timeout");
    endtask

    task automatic drain(input int rmode, input int d0);
        int cyc = 0, stall = 0;
        while (done_cnt == d0 && !abort && cyc < BUDGET) begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1;
                1: if (out_valid && n_out == 6 && stall < 5) begin
                       out_ready = 0; stall++;
                   end else out_ready = 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
        if (cyc >= BUDGET && !abort) fail("drain_timeout");
    endtask

    task automatic lat_check();
        int lat = 0;
        while (!out_valid && lat < BUDGET) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("first_out_latency", lat, K*IMG_W + K*K);
    endtask

    task automatic disturb_it();
        int c = 0;
        while (n_out < 3 && c < BUDGET) begin @(negedge clk); c++; end
        start = 1; kw_en = 1; kw_addr = KA_W'(4); kw_data = DATA_W'(100); relu_en = 1;
        @(negedge clk);
        start = 0; kw_en = 0;
    endtask

    task automatic run_frame(input int vmode, input int rmode, input bit chk_lat,
                             input bit disturb, input bit kw_last);
        int d0, o0;
        d0 = done_cnt;
        o0 = n_out;
        push_expected();
        @(negedge clk);
        start = 1; relu_en = relu_m;
        if (kw_last) begin
            kw_en = 1; kw_addr = KA_W'(K*K-1); kw_data = DATA_W'(ker[K*K-1]);
        end
        @(negedge clk);
        start = 0; kw_en = 0; relu_en = ~relu_m;
        check("busy_in_frame", busy, 1);
        fork
            feed(vmode);
            drain(rmode, d0);
            if (chk_lat) lat_check();
            if (disturb) disturb_it();
        join
        check("result_count", n_out - o0, OW*OH);
        check("done_pulses", done_cnt - d0, 1);
        check("scoreboard_empty", exp_d.size(), 0);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic set_std_kernel(input int sgn);
        for (int j = 0; j < K; j++) begin
            ker[j] = -sgn; ker[K+j] = 0; ker[2*K+j] = sgn;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        abort = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_data", out_data, 0);
        check("reset_done", done, 0);
        rst = 1;

        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = r;

        // 1: row-gradient kernel -> all 6, latency check
        set_std_kernel(1); relu_m = 0; load_kernel();
        run_frame(0, 0, 1, 0, 0);
        // 2: negated kernel, with and without ReLU
        set_std_kernel(-1); relu_m = 1; load_kernel();
        run_frame(0, 0, 0, 0, 0);
        relu_m = 0;
        run_frame(0, 0, 0, 0, 0);
        // 3: output stall at result #7 and toggling input valid
        set_std_kernel(1); load_kernel();
        run_frame(1, 1, 0, 0, 0);
        // 4: start/kw_en pulsed mid-frame are ignored; kernel unchanged after
        run_frame(0, 0, 0, 1, 0);
        run_frame(0, 0, 0, 0, 0);

        // 5: reset mid-frame
        begin
            int d0;
            d0 = done_cnt;
            push_expected();
            @(negedge clk); start = 1; relu_en = 0;
            @(negedge clk); start = 0;
            fork
                feed(0);
                drain(0, d0);
                begin
                    int c = 0;
                    while (n_out < 9 && c < BUDGET) begin @(negedge clk); c++; end
                    rst = 0;
                    @(negedge clk);
                    rst = 1; abort = 1;
                end
            join
            @(negedge clk);
            check("midreset_busy", busy, 0);
            check("midreset_out_valid", out_valid, 0);
            check("midreset_in_ready", in_ready, 0);
            check("midreset_out_data", out_data, 0);
            repeat (20) @(negedge clk);
            check("midreset_no_done", done_cnt, d0);
            abort = 0;
            exp_d.delete();
            exp_l.delete();
            for (int i = 0; i < K*K; i++) ker[i] = 0;
            run_frame(0, 0, 0, 0, 0);
        end

        // 6: signed extremes wrap the accumulator
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = -32768;
        for (int i = 0; i < K*K; i++) ker[i] = -32768;
        relu_m = 0; load_kernel();
        run_frame(0, 0, 0, 0, 0);

        // random frames; the last coefficient rides along with start
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++)
                    img[r][c] = int'($urandom_range(0, 65535)) - 32768;
            for (int i = 0; i < K*K; i++) ker[i] = int'($urandom_range(0, 65535)) - 32768;
            relu_m = 1'($urandom_range(0, 1));
            load_kernel();
            ker[K*K-1] = int'($urandom_range(0, 65535)) - 32768;
            run_frame(2, 2, 0, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
